// File: rtl/seven_seg_scan.sv
// seven_seg_scan: snapshots x or y once per frame and scans it as 8 hex digits.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits above digit0.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        sel,
  input  logic        hold,
  output logic [6:0]  out7,
  output logic [7:0]  en_out
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] BLANK_N  = DW'(BLANK_CYCLES);

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic [6:0]    out7_q, out7_d;
  logic [7:0]    en_q, en_d;
  logic          frame_start;
  logic          slot_end;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot counter, digit index and frame-start snapshot.
  always_comb begin
    slot_end    = (div_q == DIV_LAST);
    frame_start = (div_q == '0) && (idx_q == 3'd0);
    div_d       = slot_end ? '0 : div_q + 1'b1;
    idx_d       = slot_end ? idx_q + 3'd1 : idx_q;
    snap_d      = snap_q;
    if (frame_start && !hold) begin
      snap_d = sel ? y : x;
    end
  end

  // Next digit drive, blanked at slot start to avoid ghosting.
  always_comb begin
    nib   = snap_q[{idx_q, 2'b00} +: 4];
    blank = (div_q < BLANK_N);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q != 3'd0) && ((snap_q >> {idx_q, 2'b00}) == 32'd0)) begin
      blank = 1'b1;
    end
`endif
    en_d   = 8'hFF;
    out7_d = 7'h7F;
    if (!blank) begin
      en_d   = ~(8'b1 << idx_q);
      out7_d = hex7(nib);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= 3'd0;
      snap_q <= 32'd0;
      out7_q <= 7'h7F;
      en_q   <= 8'hFF;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      out7_q <= out7_d;
      en_q   <= en_d;
    end
  end

  assign out7   = out7_q;
  assign en_out = en_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed checks of scan timing, capture, hold,
// mid-frame reset and leading-zero behaviour (REFRESH_DIV=4, BLANK_CYCLES=1).
module tb_seven_seg_scan;

  localparam int DIV = 4;
  localparam int BL  = 1;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic        sel = 1'b0;
  logic        hold = 1'b0;
  logic [6:0]  out7;
  logic [7:0]  en_out;

  int tests = 0;
  int fails = 0;
  int bdiv = 0, bidx = 0;
  int pdiv = 0, pidx = 0;

  seven_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BL)) dut (
    .Clk(Clk), .rst(rst), .x(x), .y(y), .sel(sel), .hold(hold),
    .out7(out7), .en_out(en_out)
  );

  always #5 Clk = ~Clk;

  // Advance one edge; pdiv/pidx is the slot position the outputs now show.
  task automatic step();
    @(posedge Clk);
    pdiv = bdiv;
    pidx = bidx;
    if (rst) begin
      bdiv = 0;
      bidx = 0;
    end else if (bdiv == DIV - 1) begin
      bdiv = 0;
      bidx = (bidx + 1) % 8;
    end else begin
      bdiv = bdiv + 1;
    end
    #1;
  endtask

  task automatic goto_slot(input int k);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(pidx == k && pdiv == BL) && n < 100);
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL goto_slot%0d: timeout", k);
    end
  endtask

  task automatic goto_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(pidx == 0 && pdiv == 0) && n < 100);
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL goto_frame: timeout");
    end
  endtask

  task automatic test_reset();
    logic [7:0] seq [11] = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF,
                             8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFB};
    x = 32'h12345678;
    sel = 1'b0;
    hold = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (out7 !== 7'h7F || en_out !== 8'hFF) begin
        fails++;
        $display("FAIL reset_hold%0d: out7=%h en=%h want 7f ff", i, out7, en_out);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      tests++;
      if (en_out !== seq[i]) begin
        fails++;
        $display("FAIL release_seq%0d: en=%h want %h", i, en_out, seq[i]);
      end
    end
  endtask

  task automatic test_digits();
    logic [6:0] exp [8] = '{7'h00, 7'h78, 7'h02, 7'h12,
                            7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      e = ~(8'b1 << k);
      goto_slot(k);
      tests++;
      if (out7 !== exp[k] || en_out !== e) begin
        fails++;
        $display("FAIL digit%0d: out7=%h en=%h want %h %h", k, out7, en_out, exp[k], e);
      end
    end
  endtask

  task automatic test_sel_mid_frame();
    y = 32'hDEADBEEF;
    goto_slot(3);
    sel = 1'b1;
    goto_slot(5);
    tests++;
    if (out7 !== 7'h30) begin
      fails++;
      $display("FAIL sel_mid_d5: out7=%h want 30", out7);
    end
    goto_slot(7);
    tests++;
    if (out7 !== 7'h79) begin
      fails++;
      $display("FAIL sel_mid_d7: out7=%h want 79", out7);
    end
    goto_slot(0);
    tests++;
    if (out7 !== 7'h0E) begin
      fails++;
      $display("FAIL sel_y_d0: out7=%h want 0e", out7);
    end
    goto_slot(1);
    tests++;
    if (out7 !== 7'h06) begin
      fails++;
      $display("FAIL sel_y_d1: out7=%h want 06", out7);
    end
    goto_slot(7);
    tests++;
    if (out7 !== 7'h21) begin
      fails++;
      $display("FAIL sel_y_d7: out7=%h want 21", out7);
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    sel = 1'b0;
    x = 32'hFFFFFFFF;
    for (int f = 0; f < 2; f++) begin
      goto_slot(1);
      tests++;
      if (out7 !== 7'h06) begin
        fails++;
        $display("FAIL hold_f%0d_d1: out7=%h want 06", f, out7);
      end
      goto_slot(7);
      tests++;
      if (out7 !== 7'h21) begin
        fails++;
        $display("FAIL hold_f%0d_d7: out7=%h want 21", f, out7);
      end
    end
    hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      goto_slot(k);
      tests++;
      if (out7 !== 7'h0E) begin
        fails++;
        $display("FAIL unhold_d%0d: out7=%h want 0e", k, out7);
      end
    end
  endtask

  task automatic test_reset_mid();
    goto_slot(5);
    x = 32'h12345678;
    rst = 1'b1;
    step();
    tests++;
    if (out7 !== 7'h7F || en_out !== 8'hFF) begin
      fails++;
      $display("FAIL rst_mid: out7=%h en=%h want 7f ff", out7, en_out);
    end
    rst = 1'b0;
    step();
    tests++;
    if (en_out !== 8'hFF) begin
      fails++;
      $display("FAIL rst_mid_blank: en=%h want ff", en_out);
    end
    step();
    tests++;
    if (out7 !== 7'h00 || en_out !== 8'hFE) begin
      fails++;
      $display("FAIL rst_mid_d0: out7=%h en=%h want 00 fe", out7, en_out);
    end
  endtask

  task automatic test_leading_zero();
    x = 32'h000000A5;
    goto_frame();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      logic [6:0] s;
      e = ~(8'b1 << k);
      s = (k == 0) ? 7'h12 : (k == 1) ? 7'h08 : 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 1) begin
        e = 8'hFF;
        s = 7'h7F;
      end
`endif
      goto_slot(k);
      tests++;
      if (out7 !== s || en_out !== e) begin
        fails++;
        $display("FAIL a5_d%0d: out7=%h en=%h want %h %h", k, out7, en_out, s, e);
      end
    end
    for (int i = 0; i < 4 * DIV; i++) begin
      step();
      tests++;
      if ($countones(~en_out) > 1) begin
        fails++;
        $display("FAIL onehot%0d: en=%h want at most one low", i, en_out);
      end
`ifdef LEADING_ZERO_BLANK_EN
      tests++;
      if (en_out[7:2] !== 6'h3F) begin
        fails++;
        $display("FAIL a5_upper%0d: en=%h want bits 7:2 high", i, en_out);
      end
`endif
    end
    x = 32'd0;
    goto_frame();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      logic [6:0] s;
      e = ~(8'b1 << k);
      s = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0) begin
        e = 8'hFF;
        s = 7'h7F;
      end
`endif
      goto_slot(k);
      tests++;
      if (out7 !== s || en_out !== e) begin
        fails++;
        $display("FAIL zero_d%0d: out7=%h en=%h want %h %h", k, out7, en_out, s, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_sel_mid_frame();
    test_hold();
    test_reset_mid();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
